// File: rtl/core_hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core_hazard_pkg
// Description : Shared codes, state encoding and hazard-bus field offsets for
//               the Selen pipeline hazard controller.
// Revision    : 1.0 - initial release
// ============================================================================
package core_hazard_pkg;

  // Hazard commands carried alongside the instruction in EXE
  localparam logic [1:0] HZRD_OTHER = 2'b00;
  localparam logic [1:0] HZRD_BRNCH = 2'b01;
  localparam logic [1:0] HZRD_JUMP  = 2'b10;
  localparam logic [1:0] HZRD_LOAD  = 2'b11;

  // Operand forwarding selects
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EXE = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  // Hazard bus layout: {rs1, rs2, rd}
  localparam int REG_W   = 5;
  localparam int BUS_W   = 15;
  localparam int RS1_LSB = 10;
  localparam int RS2_LSB = 5;
  localparam int RD_LSB  = 0;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_IMISS = 2'd1,
    ST_DMISS = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  // Extract one register index from a hazard bus
  function automatic logic [REG_W-1:0] bus_field(input logic [BUS_W-1:0] bus, input int lsb);
    return bus[lsb +: REG_W];
  endfunction

endpackage
`default_nettype wire

// File: rtl/core_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : core_hazard_ctrl_if
// Description : Hazard bus, cache handshakes and pipeline controls between the
//               pipeline datapath (master) and the hazard controller (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface core_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             il1_ack_in;
  logic             dl1_req_in;
  logic             dl1_ack_in;
  logic [14:0]      dec_hzrd_bus_in;
  logic [14:0]      exe_hzrd_bus_in;
  logic [1:0]       exe_hzrd_cmd_in;
  logic             exe_we_in;
  logic             exe_brnch_taken_in;
  logic [4:0]       mem_rd_in;
  logic             mem_we_in;
  logic [4:0]       wb_rd_in;
  logic             wb_we_in;
  logic             if_enb_out;
  logic             dec_enb_out;
  logic             dec_kill_out;
  logic             dec_nop_gen_out;
  logic             exe_enb_out;
  logic             mem_enb_out;
  logic             pc_redirect_out;
  logic [1:0]       fwd_src1_sel_out;
  logic [1:0]       fwd_src2_sel_out;
  logic [1:0]       state_out;
  logic [CNT_W-1:0] stall_cnt_out;

  modport master (
    output il1_ack_in, dl1_req_in, dl1_ack_in, dec_hzrd_bus_in, exe_hzrd_bus_in,
           exe_hzrd_cmd_in, exe_we_in, exe_brnch_taken_in, mem_rd_in, mem_we_in,
           wb_rd_in, wb_we_in,
    input  if_enb_out, dec_enb_out, dec_kill_out, dec_nop_gen_out, exe_enb_out,
           mem_enb_out, pc_redirect_out, fwd_src1_sel_out, fwd_src2_sel_out,
           state_out, stall_cnt_out
  );

  modport slave (
    input  il1_ack_in, dl1_req_in, dl1_ack_in, dec_hzrd_bus_in, exe_hzrd_bus_in,
           exe_hzrd_cmd_in, exe_we_in, exe_brnch_taken_in, mem_rd_in, mem_we_in,
           wb_rd_in, wb_we_in,
    output if_enb_out, dec_enb_out, dec_kill_out, dec_nop_gen_out, exe_enb_out,
           mem_enb_out, pc_redirect_out, fwd_src1_sel_out, fwd_src2_sel_out,
           state_out, stall_cnt_out
  );
endinterface
`default_nettype wire

// File: rtl/core_fwd_unit.sv
`default_nettype none
// ============================================================================
// Module      : core_fwd_unit
// Description : Single-operand forwarding select. Youngest producer wins:
//               EXE, then MEM, then WB, else register file. A load still in
//               EXE has no data yet and is skipped.
// Revision    : 1.0 - initial release
// ============================================================================
module core_fwd_unit
  import core_hazard_pkg::*;
(
  input  logic [REG_W-1:0] rs,
  input  logic [REG_W-1:0] exe_rd,
  input  logic             exe_we,
  input  logic             exe_load,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             mem_we,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             wb_we,
  output logic [1:0]       sel
);

  logic exe_hit;
  logic mem_hit;
  logic wb_hit;

  // x0 is never a real destination, so rd!=0 gates every level
  assign exe_hit = exe_we & (exe_rd != '0) & (exe_rd == rs) & ~exe_load;
  assign mem_hit = mem_we & (mem_rd != '0) & (mem_rd == rs);
  assign wb_hit  = wb_we  & (wb_rd  != '0) & (wb_rd  == rs);

  // Priority select, youngest producer first
  always_comb begin
    sel = FWD_RF;
    if (exe_hit)      sel = FWD_EXE;
    else if (mem_hit) sel = FWD_MEM;
    else if (wb_hit)  sel = FWD_WB;
  end

endmodule
`default_nettype wire

// File: rtl/core_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : core_hazard_ctrl
// Description : Pipeline sequencer for the 5-stage core. Resolves D-miss,
//               branch/jump redirect, load-use and I-miss with fixed priority
//               and drives stage enables, kill, nop-gen and forwarding.
// Revision    : 1.0 - initial release
// ============================================================================
module core_hazard_ctrl
  import core_hazard_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  core_hazard_ctrl_if.slave hz
);

  state_t           state, state_nxt;
  logic [1:0]       flush_cnt, flush_cnt_nxt;
  logic [CNT_W-1:0] stall_cnt;

  logic if_enb, dec_enb, exe_enb, mem_enb;
  logic dec_kill, dec_nop_gen, pc_redirect;
  logic dmiss, redir, lduse;

  logic [REG_W-1:0] dec_rs1, dec_rs2, exe_rd, fwd_rs1, fwd_rs2;
  logic             unused_exe_src;

  assign dec_rs1 = bus_field(hz.dec_hzrd_bus_in, RS1_LSB);
  assign dec_rs2 = bus_field(hz.dec_hzrd_bus_in, RS2_LSB);
  assign exe_rd  = bus_field(hz.exe_hzrd_bus_in, RD_LSB);
  // Source fields of the EXE instruction are not needed for hazard control
  assign unused_exe_src = ^hz.exe_hzrd_bus_in[BUS_W-1:RS2_LSB];

  assign dmiss = hz.dl1_req_in & ~hz.dl1_ack_in;
  assign redir = hz.exe_brnch_taken_in | (hz.exe_hzrd_cmd_in == HZRD_JUMP);
  assign lduse = (hz.exe_hzrd_cmd_in == HZRD_LOAD) & hz.exe_we_in & (exe_rd != '0) &
                 ((exe_rd == dec_rs1) | (exe_rd == dec_rs2));

  // State, flush counter and saturating stall counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_RUN;
      flush_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
      if (!if_enb && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
    end
  end

  // Next state and pipeline controls; reset forces the safe drain values last
  always_comb begin
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    if_enb        = 1'b1;
    dec_enb       = 1'b1;
    exe_enb       = 1'b1;
    mem_enb       = 1'b1;
    dec_kill      = 1'b0;
    dec_nop_gen   = 1'b0;
    pc_redirect   = 1'b0;
    case (state)
      ST_RUN: begin
        if (dmiss) begin
          {if_enb, dec_enb, exe_enb, mem_enb} = 4'b0000;
          state_nxt = ST_DMISS;
        end else if (redir) begin
          pc_redirect   = 1'b1;
          dec_kill      = 1'b1;
          flush_cnt_nxt = 2'(FLUSH_CYCLES);
          state_nxt     = ST_FLUSH;
        end else if (lduse) begin
          // Hold IF/DEC and inject one bubble into EXE
          if_enb   = 1'b0;
          dec_kill = 1'b1;
        end else if (!hz.il1_ack_in) begin
          if_enb      = 1'b0;
          dec_nop_gen = 1'b1;
          state_nxt   = ST_IMISS;
        end
      end
      ST_IMISS: begin
        dec_nop_gen = 1'b1;
        if (dmiss) begin
          {if_enb, dec_enb, exe_enb, mem_enb} = 4'b0000;
          state_nxt = ST_DMISS;
        end else begin
          if_enb = 1'b0;
          if (hz.il1_ack_in) state_nxt = ST_RUN;
        end
      end
      ST_DMISS: begin
        if (!hz.dl1_ack_in) {if_enb, dec_enb, exe_enb, mem_enb} = 4'b0000;
        else                state_nxt = ST_RUN;
      end
      ST_FLUSH: begin
        dec_nop_gen = 1'b1;
        if (dmiss) begin
          // Freeze pauses the flush count without leaving FLUSH
          {if_enb, dec_enb, exe_enb, mem_enb} = 4'b0000;
        end else begin
          flush_cnt_nxt = flush_cnt - 2'd1;
          if (flush_cnt <= 2'd1) state_nxt = hz.il1_ack_in ? ST_RUN : ST_IMISS;
        end
      end
      default: state_nxt = ST_RUN;
    endcase
    if (rst) begin
      {if_enb, dec_enb, exe_enb, mem_enb} = 4'b0000;
      dec_kill    = 1'b1;
      dec_nop_gen = 1'b1;
      pc_redirect = 1'b0;
    end
  end

  // A nop-generated DEC instruction reads x0, which never forwards
  assign fwd_rs1 = dec_nop_gen ? '0 : dec_rs1;
  assign fwd_rs2 = dec_nop_gen ? '0 : dec_rs2;

  core_fwd_unit u_fwd_src1 (
    .rs(fwd_rs1), .exe_rd(exe_rd), .exe_we(hz.exe_we_in),
    .exe_load(hz.exe_hzrd_cmd_in == HZRD_LOAD),
    .mem_rd(hz.mem_rd_in), .mem_we(hz.mem_we_in),
    .wb_rd(hz.wb_rd_in), .wb_we(hz.wb_we_in), .sel(hz.fwd_src1_sel_out)
  );

  core_fwd_unit u_fwd_src2 (
    .rs(fwd_rs2), .exe_rd(exe_rd), .exe_we(hz.exe_we_in),
    .exe_load(hz.exe_hzrd_cmd_in == HZRD_LOAD),
    .mem_rd(hz.mem_rd_in), .mem_we(hz.mem_we_in),
    .wb_rd(hz.wb_rd_in), .wb_we(hz.wb_we_in), .sel(hz.fwd_src2_sel_out)
  );

  assign hz.if_enb_out      = if_enb;
  assign hz.dec_enb_out     = dec_enb;
  assign hz.exe_enb_out     = exe_enb;
  assign hz.mem_enb_out     = mem_enb;
  assign hz.dec_kill_out    = dec_kill;
  assign hz.dec_nop_gen_out = dec_nop_gen;
  assign hz.pc_redirect_out = pc_redirect;
  assign hz.state_out       = state;
  assign hz.stall_cnt_out   = stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_core_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_core_hazard_ctrl
// Description : Self-checking bench for core_hazard_ctrl: directed scenarios
//               followed by randomized traffic, each cycle compared against a
//               behavioural model of the sequencing rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_core_hazard_ctrl;
  import core_hazard_pkg::*;

  localparam int FLUSH_CYCLES = 2;
  localparam int CNT_W        = 5;
  localparam int STALL_MAX    = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  core_hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

  core_hazard_ctrl #(.FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .hz(hz)
  );

  always #5 clk = ~clk;

  // Model: mode 0=running, 1=waiting on I-cache, 2=waiting on D-cache, 3=flushing
  int m_mode = 0;
  int m_left = 0;
  int m_stall = 0;
  bit m_init = 0;
  bit e_if, e_dec, e_exe, e_mem, e_kill, e_nop, e_red;
  logic [1:0] e_f1, e_f2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // First producer (EXE, MEM, WB) whose destination matches rs
  function automatic logic [1:0] pick(input logic [4:0] rs);
    logic [4:0] rd[3];
    bit         ok[3];
    rd[0] = hz.exe_hzrd_bus_in[4:0];
    ok[0] = hz.exe_we_in && (hz.exe_hzrd_cmd_in != HZRD_LOAD);
    rd[1] = hz.mem_rd_in;  ok[1] = hz.mem_we_in;
    rd[2] = hz.wb_rd_in;   ok[2] = hz.wb_we_in;
    for (int i = 0; i < 3; i++)
      if (ok[i] && rd[i] != 0 && rd[i] == rs) return 2'(i + 1);
    return 2'b00;
  endfunction

  function automatic bit m_dmiss();
    return hz.dl1_req_in && !hz.dl1_ack_in;
  endfunction

  function automatic bit m_redir();
    return hz.exe_brnch_taken_in || hz.exe_hzrd_cmd_in == HZRD_JUMP;
  endfunction

  function automatic bit m_lduse();
    logic [4:0] rd;
    rd = hz.exe_hzrd_bus_in[4:0];
    return hz.exe_hzrd_cmd_in == HZRD_LOAD && hz.exe_we_in && rd != 0 &&
           (rd == hz.dec_hzrd_bus_in[14:10] || rd == hz.dec_hzrd_bus_in[9:5]);
  endfunction

  task automatic eval_model();
    bit frozen;
    {e_if, e_dec, e_exe, e_mem} = 4'b1111;
    {e_kill, e_nop, e_red} = 3'b000;
    if (rst) begin
      {e_if, e_dec, e_exe, e_mem} = 4'b0000;
      e_kill = 1; e_nop = 1;
    end else begin
      e_nop  = (m_mode == 1 || m_mode == 3);
      frozen = (m_mode == 2) ? !hz.dl1_ack_in : m_dmiss();
      if (frozen) {e_if, e_dec, e_exe, e_mem} = 4'b0000;
      else if (m_mode == 1) e_if = 0;
      else if (m_mode == 0) begin
        if (m_redir()) begin e_red = 1; e_kill = 1; end
        else if (m_lduse()) begin e_if = 0; e_kill = 1; end
        else if (!hz.il1_ack_in) begin e_if = 0; e_nop = 1; end
      end
    end
    e_f1 = e_nop ? 2'b00 : pick(hz.dec_hzrd_bus_in[14:10]);
    e_f2 = e_nop ? 2'b00 : pick(hz.dec_hzrd_bus_in[9:5]);
  endtask

  task automatic advance_model();
    if (rst) begin
      m_mode = 0; m_left = 0; m_stall = 0; m_init = 1;
    end else begin
      if (!e_if && m_stall < STALL_MAX) m_stall++;
      case (m_mode)
        0: if (m_dmiss()) m_mode = 2;
           else if (m_redir()) begin m_mode = 3; m_left = FLUSH_CYCLES; end
           else if (!m_lduse() && !hz.il1_ack_in) m_mode = 1;
        1: if (m_dmiss()) m_mode = 2; else if (hz.il1_ack_in) m_mode = 0;
        2: if (hz.dl1_ack_in) m_mode = 0;
        default: if (!m_dmiss()) begin
          if (m_left == 1) m_mode = hz.il1_ack_in ? 0 : 1;
          else m_left--;
        end
      endcase
    end
  endtask

  // One clock: compare at negedge with the inputs already applied, then advance
  task automatic step();
    @(negedge clk);
    eval_model();
    check("enb",  {hz.if_enb_out, hz.dec_enb_out, hz.exe_enb_out, hz.mem_enb_out},
                  {e_if, e_dec, e_exe, e_mem});
    check("ctl",  {hz.dec_kill_out, hz.dec_nop_gen_out, hz.pc_redirect_out},
                  {e_kill, e_nop, e_red});
    check("fwd1", hz.fwd_src1_sel_out, e_f1);
    check("fwd2", hz.fwd_src2_sel_out, e_f2);
    if (m_init) begin
      check("state", hz.state_out, m_mode);
      check("stall", hz.stall_cnt_out, m_stall);
    end
    @(posedge clk);
    advance_model();
    #1;
  endtask

  task automatic quiet();
    rst = 0;
    hz.il1_ack_in = 1; hz.dl1_req_in = 0; hz.dl1_ack_in = 0;
    hz.dec_hzrd_bus_in = '0; hz.exe_hzrd_bus_in = '0; hz.exe_hzrd_cmd_in = HZRD_OTHER;
    hz.exe_we_in = 0; hz.exe_brnch_taken_in = 0;
    hz.mem_rd_in = '0; hz.mem_we_in = 0; hz.wb_rd_in = '0; hz.wb_we_in = 0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    quiet();
    rst = 1; run(2);
    rst = 0; run(2);

    // Load-use on rs1
    hz.exe_hzrd_cmd_in = HZRD_LOAD; hz.exe_we_in = 1;
    hz.exe_hzrd_bus_in = {5'd0, 5'd0, 5'd5}; hz.dec_hzrd_bus_in = {5'd5, 5'd1, 5'd2};
    step();
    quiet(); hz.dec_hzrd_bus_in = {5'd5, 5'd1, 5'd2}; run(2);

    // Taken branch then flush
    hz.exe_brnch_taken_in = 1; step();
    hz.exe_brnch_taken_in = 0; run(4);

    // D-miss with a concurrent taken branch
    hz.dl1_req_in = 1; hz.exe_brnch_taken_in = 1; run(4);
    hz.dl1_ack_in = 1; step();
    hz.dl1_req_in = 0; hz.dl1_ack_in = 0; step();
    hz.exe_brnch_taken_in = 0; run(3);

    // I-miss
    hz.il1_ack_in = 0; run(3);
    hz.il1_ack_in = 1; run(2);

    // Forwarding priority
    hz.exe_hzrd_bus_in = {5'd0, 5'd0, 5'd7}; hz.mem_rd_in = 7; hz.wb_rd_in = 7;
    hz.exe_we_in = 1; hz.mem_we_in = 1; hz.wb_we_in = 1;
    hz.dec_hzrd_bus_in = {5'd3, 5'd7, 5'd1}; step();
    hz.exe_we_in = 0; step();
    hz.mem_we_in = 0; step();
    hz.dec_hzrd_bus_in = {5'd7, 5'd0, 5'd1}; hz.mem_rd_in = 0; hz.wb_rd_in = 0;
    hz.exe_hzrd_bus_in = '0; hz.mem_we_in = 1; hz.wb_we_in = 1; step();

    // Reset mid D-miss
    quiet(); hz.dl1_req_in = 1; run(2);
    rst = 1; step();
    rst = 0; run(2);
    quiet(); run(1);

    // Long I-miss drives the stall counter into saturation
    hz.il1_ack_in = 0; run(STALL_MAX + 6);
    hz.il1_ack_in = 1; run(2);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom % 64) == 0;
      hz.il1_ack_in = ($urandom % 4) != 0;
      hz.dl1_req_in = ($urandom % 3) == 0;
      hz.dl1_ack_in = $urandom % 2;
      hz.dec_hzrd_bus_in = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      hz.exe_hzrd_bus_in = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      hz.exe_hzrd_cmd_in = 2'($urandom);
      hz.exe_we_in = $urandom % 2;
      hz.exe_brnch_taken_in = ($urandom % 6) == 0;
      hz.mem_rd_in = 5'($urandom_range(0, 7));
      hz.mem_we_in = $urandom % 2;
      hz.wb_rd_in = 5'($urandom_range(0, 7));
      hz.wb_we_in = $urandom % 2;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/core_hazard_ctrl.md
Name: core_hazard_ctrl

Overview:
Pipeline sequencer for the Selen 5-stage core (IF, DEC, EXE, MEM, WB). It consumes the hazard bus and hazard command emitted by the decode stage, plus the I-cache and D-cache handshakes. It generates the per-stage enable, kill and nop-generate controls, the PC redirect and the operand forwarding selects. It resolves I-cache misses, D-cache misses, load-use hazards and branch/jump flushes with a fixed priority.

Parameters:
FLUSH_CYCLES, 1, cycles of dec_nop_gen after a redirect (legal 1..3)
CNT_W, 16, width of the saturating stall-cycle counter

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
il1_ack_in  in  1  L1I returned a valid instruction this cycle
dl1_req_in  in  1  MEM stage holds a valid L1D request
dl1_ack_in  in  1  L1D completed the request
dec_hzrd_bus_in  in  15  {rs1,rs2,rd} of the instruction currently in DEC
exe_hzrd_bus_in  in  15  {rs1,rs2,rd} of the instruction in EXE (registered decode output)
exe_hzrd_cmd_in  in  2  hazard command of the instruction in EXE
exe_we_in  in  1  EXE instruction writes the register file
exe_brnch_taken_in  in  1  EXE branch resolved taken
mem_rd_in  in  5  MEM destination register
mem_we_in  in  1  MEM writes the register file
wb_rd_in  in  5  WB destination register
wb_we_in  in  1  WB writes the register file
if_enb_out  out  1  PC/IF register advance
dec_enb_out  out  1  DEC/EXE register load (drives dec_enb)
dec_kill_out  out  1  clear DEC/EXE register (drives dec_kill)
dec_nop_gen_out  out  1  treat DEC instruction as nop (drives dec_nop_gen_in)
exe_enb_out  out  1  EXE/MEM register load
mem_enb_out  out  1  MEM/WB register load
pc_redirect_out  out  1  IF selects the EXE target PC
fwd_src1_sel_out  out  2  operand-1 forwarding select
fwd_src2_sel_out  out  2  operand-2 forwarding select
state_out  out  2  FSM state, for debug
stall_cnt_out  out  CNT_W  saturating count of cycles with if_enb_out=0

Behaviour:
- Hazard bus layout: [14:10] rs1, [9:5] rs2, [4:0] rd. HZRD_OTHER=2'b00, HZRD_BRNCH=2'b01, HZRD_JUMP=2'b10, HZRD_LOAD=2'b11.
- FSM states: RUN=0, IMISS=1, DMISS=2, FLUSH=3. The state register and the flush counter are clocked. All other outputs are combinational from state and inputs.
- Reset values: while rst=1 the outputs are forced as follows:
  - all *_enb=0
  - dec_kill=1, dec_nop_gen=1
  - pc_redirect=0, fwd=00
- Reset action: the first clk edge with rst=1 sets state=RUN and clears the flush counter and stall_cnt. Reset asserted mid-miss or mid-flush aborts the operation with no pending redirect retained.
- Derived signals:
  - dmiss = dl1_req_in & ~dl1_ack_in
  - redir = exe_brnch_taken_in | (exe_hzrd_cmd_in==HZRD_JUMP)
  - lduse = (exe_hzrd_cmd_in==HZRD_LOAD) & exe_we_in & exe.rd!=0 & (exe.rd==dec.rs1 | exe.rd==dec.rs2)
- Priority in RUN, highest first:
  1. dmiss: all enables 0, no kill, so the pipe freezes and a pending redir is deferred. Next state DMISS.
  2. redir: pc_redirect=1, dec_kill=1, if_enb=1, exe/mem_enb=1. Counter loads FLUSH_CYCLES. Next state FLUSH.
  3. lduse: if_enb=0, dec_kill=1 (one bubble into EXE), exe/mem_enb=1. Stay in RUN; resolved in one cycle.
  4. ~il1_ack_in: if_enb=0, dec_nop_gen=1, exe/mem_enb=1. Next state IMISS.
  5. Otherwise all enables 1, no kill/nop.
- DMISS: full freeze held until dl1_ack_in. On the ack cycle all enables are 1 and next state is RUN.
- IMISS: if_enb=0 and dec_nop_gen=1. dmiss still takes precedence and moves to DMISS. On il1_ack_in, next state is RUN.
- FLUSH: dec_nop_gen=1 and the counter decrements each cycle. dmiss freezes the pipe and pauses the counter without leaving FLUSH. When the counter reaches 1:
  - to RUN if il1_ack_in
  - else to IMISS
- Forwarding, per operand, compared against dec.rs: EXE (01) if exe_we & exe.rd!=0 & match & cmd!=HZRD_LOAD; else MEM (10); else WB (11); else RF (00). The compare uses rd!=0 & we & match at every level. With dec_nop_gen=1, rs=0, so the select is always 00.
- stall_cnt increments by 1 when if_enb_out=0 and rst=0, and saturates at all-ones.

Decomposition:
- Package core_hazard_pkg holds:
  - HZRD_* and FWD_* codes
  - the state enum
  - hazard bus field offsets
- Sub-module core_fwd_unit is the combinational single-operand priority compare. It is instantiated twice.

Test Plan:
- Load-use: EXE cmd=HZRD_LOAD, exe.rd=5, exe_we=1; DEC rs1=5 -> exactly one cycle of if_enb=0 and dec_kill=1; next cycle all enables 1.
- Taken branch with FLUSH_CYCLES=2 -> pc_redirect=1 and dec_kill=1 for one cycle, then 2 cycles of dec_nop_gen=1, state RUN (0) afterwards.
- D-miss: dl1_req=1, ack delayed 4 cycles, with exe_brnch_taken=1 concurrently -> 4 cycles with all enables 0 and no redirect; redirect asserts on the cycle after the ack cycle.
- I-miss: il1_ack=0 for 3 cycles -> state IMISS, if_enb=0, dec_nop_gen=1, stall_cnt increments by 3.
- Forwarding: exe.rd=mem.rd=wb.rd=7, all we=1, dec rs2=7 -> fwd_src2=01; exe_we=0 -> 10; rd=0 -> 00.
- Reset mid-DMISS: rst=1 for one cycle -> outputs at reset values, state_out=0, stall_cnt=0.
